// File: rtl/sprite_move_scheduler.sv
// Time-shares the VGA plot port among four sprite controllers: each granted move
// runs a 256-pixel clear pass, then a 256-pixel shifted redraw pass.
module sprite_move_scheduler (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [3:0]  axis,
    input  logic [27:0] amount,
    output logic [3:0]  ack,
    output logic        busy,
    output logic [3:0]  spr_draw,
    output logic        spr_clear,
    output logic        spr_shift_h,
    output logic        spr_shift_v,
    output logic [6:0]  spr_shift_amount,
    input  logic [31:0] spr_x,
    input  logic [27:0] spr_y,
    input  logic [47:0] spr_colour,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [11:0] vga_colour,
    output logic        plot
);
    localparam int N_SPR = 4;

    typedef enum logic [2:0] {S_IDLE, S_GRANT, S_CLEAR, S_SHIFT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        axis_q, axis_d;
    logic [6:0]  amt_q, amt_d;

    logic [3:0]  draw_q, ack_q;
    logic        clear_q, shift_h_q, shift_v_q, busy_q, plot_q;
    logic [7:0]  vga_x_q;
    logic [6:0]  vga_y_q;
    logic [11:0] vga_colour_q;

    logic [6:0]  amt_lane    [N_SPR];
    logic [7:0]  x_lane      [N_SPR];
    logic [6:0]  y_lane      [N_SPR];
    logic [11:0] colour_lane [N_SPR];

    genvar gi;
    generate
        for (gi = 0; gi < N_SPR; gi++) begin : g_lane
            assign amt_lane[gi]    = amount[7*gi +: 7];
            assign x_lane[gi]      = spr_x[8*gi +: 8];
            assign y_lane[gi]      = spr_y[7*gi +: 7];
            assign colour_lane[gi] = spr_colour[12*gi +: 12];
        end
    endgenerate

    // Round-robin search starting just above the last sprite served.
    logic       arb_found;
    logic [1:0] arb_idx;
    logic [1:0] cand;
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_q;
        cand      = last_q;
        for (int k = 1; k <= N_SPR; k++) begin
            cand = last_q + 2'(k);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        axis_d  = axis_q;
        amt_d   = amt_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    state_d = S_GRANT;
                    gnt_d   = arb_idx;
                end
            end
            S_GRANT: begin
                axis_d  = axis[gnt_q];
                amt_d   = amt_lane[gnt_q];
                cnt_d   = 8'd0;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd255) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd255) state_d = S_DONE;
            end
            S_DONE: begin
                last_d  = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic active_d, active_q;
    assign active_d = (state_d == S_CLEAR) || (state_d == S_SHIFT);
    assign active_q = (state_q == S_CLEAR) || (state_q == S_SHIFT);

    // Command outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            last_q       <= 2'd3;
            gnt_q        <= 2'd0;
            axis_q       <= 1'b0;
            amt_q        <= 7'd0;
            draw_q       <= 4'd0;
            ack_q        <= 4'd0;
            clear_q      <= 1'b0;
            shift_h_q    <= 1'b0;
            shift_v_q    <= 1'b0;
            busy_q       <= 1'b0;
            plot_q       <= 1'b0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 12'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            axis_q       <= axis_d;
            amt_q        <= amt_d;
            draw_q       <= active_d ? (4'b0001 << gnt_d) : 4'd0;
            ack_q        <= (state_d == S_DONE) ? (4'b0001 << gnt_d) : 4'd0;
            clear_q      <= (state_d == S_CLEAR);
            shift_h_q    <= (state_d == S_SHIFT) && !axis_d;
            shift_v_q    <= (state_d == S_SHIFT) && axis_d;
            busy_q       <= (state_d != S_IDLE);
            plot_q       <= active_q;
            vga_x_q      <= x_lane[gnt_q];
            vga_y_q      <= y_lane[gnt_q];
            vga_colour_q <= colour_lane[gnt_q];
        end
    end

    assign ack              = ack_q;
    assign busy             = busy_q;
    assign spr_draw         = draw_q;
    assign spr_clear        = clear_q;
    assign spr_shift_h      = shift_h_q;
    assign spr_shift_v      = shift_v_q;
    assign spr_shift_amount = amt_q;
    assign vga_x            = vga_x_q;
    assign vga_y            = vga_y_q;
    assign vga_colour       = vga_colour_q;
    assign plot             = plot_q;

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Directed bench for sprite_move_scheduler: a table of single moves plus hand-written
// round-robin, mid-move change and mid-move reset sequences, against a sprite-controller model.
module tb_sprite_move_scheduler;
    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [3:0]  axis;
    logic [27:0] amount;
    logic [3:0]  ack;
    logic        busy;
    logic [3:0]  spr_draw;
    logic        spr_clear, spr_shift_h, spr_shift_v;
    logic [6:0]  spr_shift_amount;
    logic [31:0] spr_x = '0;
    logic [27:0] spr_y = '0;
    logic [47:0] spr_colour = '0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [11:0] vga_colour;
    logic        plot;

    always #5 clk = ~clk;

    sprite_move_scheduler dut (
        .clk(clk), .resetn(resetn), .req(req), .axis(axis), .amount(amount),
        .ack(ack), .busy(busy), .spr_draw(spr_draw), .spr_clear(spr_clear),
        .spr_shift_h(spr_shift_h), .spr_shift_v(spr_shift_v),
        .spr_shift_amount(spr_shift_amount), .spr_x(spr_x), .spr_y(spr_y),
        .spr_colour(spr_colour), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .plot(plot)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cyc_g = -1;

    // Sprite controller model: presents pixel ptr on the falling edge, advances when drawn.
    logic [7:0] ptr [4] = '{default: 8'd0};
    logic [7:0] mp;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            mp = ptr[i];
            spr_x[i*8 +: 8]       = 8'(i*40) + {4'h0, mp[3:0]}
                                  + ((spr_draw[i] && spr_shift_h) ? {1'b0, spr_shift_amount} : 8'd0);
            spr_y[i*7 +: 7]       = {3'b000, mp[7:4]}
                                  + ((spr_draw[i] && spr_shift_v) ? spr_shift_amount : 7'd0);
            spr_colour[i*12 +: 12] = (spr_draw[i] && spr_clear) ? 12'd0 : 12'(int'(mp)*5 + i + 1);
            if (spr_draw[i]) ptr[i] = mp + 8'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Runs one move from the IDLE cycle where req is already presented; c counts from GRANT=0.
    task automatic run_move(input int g, input bit ax, input int amt, input int chg_cycle,
                            input logic [27:0] new_amount, input int drop_cycle,
                            input int abort_cycle, input bit chk_same);
        logic [3:0] oh;
        logic [3:0] exp_draw;
        logic [3:0] draw1;
        bit         exp_clear, exp_shift;
        int bad_cmd, bad_amt, bad_ack, bad_busy, bad_plot, bad_vga, bad_same, nplot, bad_rst;
        logic [7:0] cx [256];
        logic [6:0] cy [256];
        oh = 4'b0001 << g;
        draw1 = 4'd0;
        bad_cmd = 0; bad_amt = 0; bad_ack = 0; bad_busy = 0; bad_plot = 0;
        bad_vga = 0; bad_same = 0; nplot = 0; bad_rst = 0;
        ack_cyc_g = -1;
        for (int c = 0; c <= 514; c++) begin
            step();
            if (c == abort_cycle) begin
                resetn = 1'b0;
                #1;
                check("async_reset_outputs",
                      int'(|{ack, busy, spr_draw, spr_clear, spr_shift_h, spr_shift_v,
                             spr_shift_amount, vga_x, vga_y, vga_colour, plot}), 0);
                for (int k = 0; k < 3; k++) begin
                    step();
                    if (ack != 4'd0 || busy || plot || spr_draw != 4'd0) bad_rst++;
                end
                check("reset_hold_no_ack", bad_rst, 0);
                resetn = 1'b1;
                return;
            end
            exp_draw  = (c >= 1 && c <= 512) ? oh : 4'd0;
            exp_clear = (c >= 1 && c <= 256);
            exp_shift = (c >= 257 && c <= 512);
            if (c == 1) draw1 = spr_draw;
            if (spr_draw !== exp_draw || spr_clear !== exp_clear ||
                spr_shift_h !== (exp_shift && !ax) || spr_shift_v !== (exp_shift && ax))
                bad_cmd++;
            if (c >= 1 && spr_shift_amount !== 7'(amt)) bad_amt++;
            if (ack !== ((c == 513) ? oh : 4'd0)) bad_ack++;
            if (c == 513 && ack == oh) ack_cyc_g = cyc;
            if (busy !== (c <= 513)) bad_busy++;
            if (plot !== (c >= 2 && c <= 513)) bad_plot++;
            if (plot) nplot++;
            if (c >= 1 && c <= 513 &&
                (vga_x !== spr_x[g*8 +: 8] || vga_y !== spr_y[g*7 +: 7] ||
                 vga_colour !== spr_colour[g*12 +: 12]))
                bad_vga++;
            if (chk_same && c >= 2 && c <= 257) begin
                cx[c-2] = vga_x;
                cy[c-2] = vga_y;
                if (vga_colour != 12'd0) bad_same++;
            end
            if (chk_same && c >= 258 && c <= 513) begin
                if (vga_x != cx[c-258] || vga_y != cy[c-258] || vga_colour == 12'd0) bad_same++;
            end
            if (c == chg_cycle) amount = new_amount;
            if (c == drop_cycle) req = req & ~oh;
        end
        check("grant_onehot", int'(draw1), int'(oh));
        check("cmd_bad_cycles", bad_cmd, 0);
        check("shift_amount_bad_cycles", bad_amt, 0);
        check("ack_bad_cycles", bad_ack, 0);
        check("busy_bad_cycles", bad_busy, 0);
        check("plot_bad_cycles", bad_plot, 0);
        check("plot_count", nplot, 512);
        check("vga_follow_bad_cycles", bad_vga, 0);
        if (chk_same) check("inplace_redraw_bad_pixels", bad_same, 0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  axis;
        logic [27:0] amount;
        int          exp_g;
        bit          exp_ax;
        int          exp_amt;
        bit          chk_same;
    } vec_t;

    vec_t tbl [5];
    int   prev_ack;

    initial begin
        // amount vectors are written lane 3 .. lane 0
        tbl[0] = '{req: 4'b0001, axis: 4'b0000, amount: {7'd0, 7'd0, 7'd0, 7'd3},
                   exp_g: 0, exp_ax: 1'b0, exp_amt: 3, chk_same: 1'b0};
        tbl[1] = '{req: 4'b0100, axis: 4'b0100, amount: {7'd0, 7'd5, 7'd0, 7'd0},
                   exp_g: 2, exp_ax: 1'b1, exp_amt: 5, chk_same: 1'b0};
        tbl[2] = '{req: 4'b1010, axis: 4'b0000, amount: {7'd0, 7'd0, 7'd33, 7'd0},
                   exp_g: 3, exp_ax: 1'b0, exp_amt: 0, chk_same: 1'b1};
        tbl[3] = '{req: 4'b1010, axis: 4'b0010, amount: {7'd11, 7'd0, 7'd127, 7'd0},
                   exp_g: 1, exp_ax: 1'b1, exp_amt: 127, chk_same: 1'b0};
        tbl[4] = '{req: 4'b1001, axis: 4'b1001, amount: {7'd64, 7'd0, 7'd0, 7'd2},
                   exp_g: 3, exp_ax: 1'b1, exp_amt: 64, chk_same: 1'b0};

        resetn = 1'b0; req = 4'd0; axis = 4'd0; amount = 28'd0;
        for (int k = 0; k < 3; k++) step();
        check("reset_ack", int'(ack), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_draw", int'(spr_draw), 0);
        check("reset_clear_shift", int'({spr_clear, spr_shift_h, spr_shift_v}), 0);
        check("reset_shift_amount", int'(spr_shift_amount), 0);
        check("reset_vga", int'({vga_x, vga_y, vga_colour}), 0);
        check("reset_plot", int'(plot), 0);
        resetn = 1'b1;
        step();
        check("idle_no_req_busy", int'(busy), 0);

        for (int t = 0; t < 5; t++) begin
            req = tbl[t].req; axis = tbl[t].axis; amount = tbl[t].amount;
            run_move(tbl[t].exp_g, tbl[t].exp_ax, tbl[t].exp_amt, -1, 28'd0, -1, -1,
                     tbl[t].chk_same);
            $display("move %0d: req=%b granted lane %0d ack at cycle %0d", t, tbl[t].req,
                     tbl[t].exp_g, ack_cyc_g);
        end

        // All four requesting and holding: rotation 0,1,2,3,0 at 515-cycle spacing.
        req = 4'b1111; axis = 4'b0000; amount = {7'd40, 7'd30, 7'd20, 7'd10};
        prev_ack = -1;
        for (int k = 0; k < 5; k++) begin
            run_move(k % 4, 1'b0, 10 * ((k % 4) + 1), -1, 28'd0, -1, -1, 1'b0);
            $display("round-robin move %0d: lane %0d ack at cycle %0d", k, k % 4, ack_cyc_g);
            if (k > 0) check("ack_spacing", ack_cyc_g - prev_ack, 515);
            prev_ack = ack_cyc_g;
        end

        // Amount changes during CLEAR and req drops mid-SHIFT; latched 4 still used, ack still comes.
        req = 4'b0010; axis = 4'b0000; amount = {7'd0, 7'd0, 7'd4, 7'd0};
        run_move(1, 1'b0, 4, 100, {7'd0, 7'd0, 7'd9, 7'd0}, 300, -1, 1'b0);
        $display("amount-change move: lane 1 ack at cycle %0d", ack_cyc_g);

        // Leave last grant at 0, then reset mid-CLEAR of a lane-2 move.
        req = 4'b0001; amount = {7'd0, 7'd0, 7'd0, 7'd6};
        run_move(0, 1'b0, 6, -1, 28'd0, -1, -1, 1'b0);
        $display("pre-reset move: lane 0 ack at cycle %0d", ack_cyc_g);
        req = 4'b0100; amount = {7'd0, 7'd7, 7'd0, 7'd6};
        run_move(2, 1'b0, 7, -1, 28'd0, -1, 100, 1'b0);
        $display("reset applied at cycle %0d of lane 2 move", 100);

        req = 4'b0011; amount = {7'd0, 7'd0, 7'd8, 7'd2};
        run_move(0, 1'b0, 2, -1, 28'd0, -1, -1, 1'b0);
        $display("post-reset move: lane 0 ack at cycle %0d", ack_cyc_g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sprite_move_scheduler.md
# sprite_move_scheduler

Shares the single VGA plot port among four 16x16 sprite controllers and sequences each sprite move as a clear pass followed by a shifted redraw pass. Requesters post move requests. A round-robin arbiter grants one sprite at a time. The block drives that sprite's draw/clear/shift command lines, registers its pixel stream and presents it to the VGA adapter with a plot strobe.

## Interface
- N_SPR, 4: number of sprite controllers. Fixed; indices 0..3.
- PASS_LEN, 256: pixels per pass, one 16x16 sprite.
- clk  in  1  system clock, rising edge. Sprite controllers update on the falling edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  4  per-sprite move request. Level; held until the matching ack.
- axis  in  4  per-sprite axis: 0 horizontal, 1 vertical.
- amount  in  28  per-sprite shift amount, 7 bits each; sprite i uses [7i+6:7i].
- ack  out  4  one-cycle pulse when the move for sprite i completes.
- busy  out  1  high whenever state is not IDLE.
- spr_draw  out  4  one-hot draw enable to the granted sprite.
- spr_clear  out  1  broadcast clear command.
- spr_shift_h  out  1  broadcast horizontal shift command.
- spr_shift_v  out  1  broadcast vertical shift command.
- spr_shift_amount  out  7  broadcast latched amount.
- spr_x  in  32  sprite pixel x, 8 bits each.
- spr_y  in  28  sprite pixel y, 7 bits each.
- spr_colour  in  48  sprite pixel colour, 12 bits each.
- vga_x  out  8  registered pixel x.
- vga_y  out  7  registered pixel y.
- vga_colour  out  12  registered pixel colour.
- plot  out  1  vga_x/vga_y/vga_colour are valid this cycle.

## Operation
- States:
  - IDLE -> GRANT when any req bit is high.
  - GRANT -> CLEAR after 1 cycle.
  - CLEAR -> SHIFT after 256 cycles.
  - SHIFT -> DONE after 256 cycles.
  - DONE -> IDLE after 1 cycle.
- Arbitration, evaluated in IDLE: round-robin, searching upward from last_grant+1 modulo 4. The first req bit found wins. last_grant resets to 3, so sprite 0 has first priority.
- GRANT cycle:
  - Latch grant index g, axis[g] and amount[g] into internal registers.
  - No sprite command outputs are asserted.
- CLEAR state:
  - spr_draw[g]=1, spr_clear=1, shift lines 0.
  - 8-bit pixel counter counts 0..255; the 255->0 wrap moves the state to SHIFT.
- SHIFT state:
  - spr_draw[g]=1, spr_clear=0.
  - spr_shift_h=~axis_l and spr_shift_v=axis_l.
  - spr_shift_amount=amount_l.
  - Same counter; the wrap moves the state to DONE.
- DONE state: ack[g]=1 for one cycle and last_grant<=g. All spr_* outputs are 0.
- Pixel path: every cycle, at the rising edge, register spr_x/spr_y/spr_colour of lane g into vga_*. Set plot to 1 if the state during the closing cycle was CLEAR or SHIFT, else 0.
- spr_shift_amount holds the latched value outside SHIFT. All other spr_* outputs are 0 outside CLEAR/SHIFT.
- Requests changing after GRANT have no effect on the move in progress. Dropping req[g] mid-move does not abort it; ack[g] still pulses.
- amount=0 still executes both passes, redrawing the sprite in place.
- Requests from other sprites during a move wait. They are arbitrated in the next IDLE cycle.

## Timing
- Reset values: state IDLE, counter 0, last_grant 3, amount_l 0, axis_l 0. All outputs 0: ack, busy, spr_*, vga_x, vga_y, vga_colour, plot.
- resetn low at any point forces the reset values immediately, asynchronously. Any in-progress move is abandoned with no ack. The sprite controller's internal pointer is not repaired by this block.
- Cycle numbering: GRANT = cycle 0, CLEAR = cycles 1..256, SHIFT = cycles 257..512, DONE = cycle 513, IDLE = cycle 514.
- plot is high for cycles 2..513, exactly 512 consecutive cycles.
  - Cycles 2..257 carry clear pixels, colour 0.
  - Cycles 258..513 carry shifted sprite pixels.
- ack pulses in cycle 513, together with the last plotted pixel.
- Earliest next GRANT is cycle 515, so back-to-back moves are 515 cycles apart.
- busy is high for cycles 0..513.

## Test plan
- Single move: req=0001, axis[0]=0, amount=3.
  - Required: spr_draw=0001 and spr_clear=1 for 256 cycles, then spr_shift_h=1 with spr_shift_amount=3 for 256 cycles.
  - Required: plot high for 512 consecutive cycles; ack=0001 in cycle 513.
- Simultaneous req=1111 held after each ack.
  - Required grant order: 0,1,2,3,0.
  - Required: each ack 515 cycles after the previous one.
- Vertical move: req[2]=1, axis[2]=1, amount=5.
  - Required in SHIFT: spr_shift_v=1, spr_shift_h=0, spr_shift_amount=5, spr_draw=0100.
  - Required: vga_* follows lane 2 delayed by one cycle.
- amount change mid-move: amount[1] changes from 4 to 9 during CLEAR.
  - Required: SHIFT presents 4.
  - Required: req[1] dropped at cycle 300 still yields ack[1] at cycle 513.
- resetn pulsed low at cycle 100 of CLEAR.
  - Required: all outputs 0 in the same cycle and no ack.
  - Required after release with req=0011: sprite 0 is granted first.
- amount=0 on sprite 3.
  - Required: both passes run, 512 plots; clear pixels have colour 0 and redraw pixels are at the same coordinates.
